mem_stage_access_unit: RTL and testbench

//  Consumer end of the EX/MEM pipeline register: takes the registered MEM-stage bundle, performs the

---
 rtl/mem_stage_access_unit_pkg.sv | 22 ++
 rtl/mem_stage_access_unit_mem_wb_registers.sv | 35 +++
 rtl/mem_stage_access_unit.sv | 160 ++++++++++++++++
 tb/tb_mem_stage_access_unit.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_access_unit_pkg.sv
// Shared definitions for the MEM-stage access unit.
//   memState_t  : access FSM encoding (IDLE=0, WAIT=1, DONE=2)
//   wbBundle_t  : one MEM/WB pipeline register entry
//   BUBBLE_WB   : value loaded into MEM/WB when no instruction retires
package mem_stage_access_unit_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } memState_t;

   typedef struct packed {
      logic [31:0] instruction;
      logic        shouldWriteRegister;
      logic [4:0]  registerWriteAddress;
      logic [31:0] registerWriteData;
   } wbBundle_t;

   localparam wbBundle_t BUBBLE_WB = '0;

endpackage

// File: rtl/mem_stage_access_unit_mem_wb_registers.sv
// Plain MEM/WB pipeline register.
// Ports:
//   clk, rst        clock, synchronous active-high reset (clears to bubble)
//   loadEnable      1: capture wbIn, 0: load a bubble
//   wbIn            bundle presented by the MEM stage
//   wb_*            registered MEM/WB outputs
module mem_wb_registers
   import mem_stage_access_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        loadEnable,
   input  wbBundle_t   wbIn,
   output logic [31:0] wb_instruction,
   output logic        wb_shouldWriteRegister,
   output logic [4:0]  wb_registerWriteAddress,
   output logic [31:0] wb_registerWriteData
);

   wbBundle_t wbReg;

   always_ff @(posedge clk) begin
      if (rst || !loadEnable) begin
         wbReg <= BUBBLE_WB;
      end else begin
         wbReg <= wbIn;
      end
   end

   assign wb_instruction          = wbReg.instruction;
   assign wb_shouldWriteRegister  = wbReg.shouldWriteRegister;
   assign wb_registerWriteAddress = wbReg.registerWriteAddress;
   assign wb_registerWriteData    = wbReg.registerWriteData;

endmodule

// File: rtl/mem_stage_access_unit.sv
// MEM-stage access unit: consumes the EX/MEM bundle, performs a data-memory
// access over a req/ack handshake and loads the MEM/WB register.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   mem_*                  EX/MEM bundle (held by upstream while memStall=1)
//   dmemRequest/WriteEnable/Address/WriteData   request side, held until ack
//   dmemReadData/dmemAck   response side, ack is a one-cycle pulse
//   memStall               combinational stall to the upstream pipeline
//   memError               sticky access-timeout flag
//   wb_*                   MEM/WB register outputs
// Optional feature: define MEM_ACCESS_TIMEOUT_EN to abort a WAIT after
// TIMEOUT_CYCLES cycles without ack (captured data 0, memError set).
module mem_stage_access_unit
   import mem_stage_access_unit_pkg::*;
#(
   parameter int ADDR_WIDTH     = 10,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           mem_instruction,
   input  logic                  mem_shouldWriteRegister,
   input  logic [4:0]            mem_registerWriteAddress,
   input  logic                  mem_shouldWriteMemoryElseAluOutputToRegister,
   input  logic [31:0]           mem_aluOutput,
   input  logic                  mem_shouldWriteMemory,
   input  logic [31:0]           mem_registerRtOrZero,
   output logic                  dmemRequest,
   output logic                  dmemWriteEnable,
   output logic [ADDR_WIDTH-1:0] dmemAddress,
   output logic [31:0]           dmemWriteData,
   input  logic [31:0]           dmemReadData,
   input  logic                  dmemAck,
   output logic                  memStall,
   output logic                  memError,
   output logic [31:0]           wb_instruction,
   output logic                  wb_shouldWriteRegister,
   output logic [4:0]            wb_registerWriteAddress,
   output logic [31:0]           wb_registerWriteData
);

   memState_t   state, stateNext;
   logic        access;
   logic        waitExpired;
   logic        wbLoad;
   logic [31:0] capturedData;
   wbBundle_t   wbNext;

   assign access = mem_shouldWriteMemory | mem_shouldWriteMemoryElseAluOutputToRegister;

`ifdef MEM_ACCESS_TIMEOUT_EN
   localparam int COUNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [COUNT_W-1:0] waitCount;
   logic               memErrorReg;

   // waitCount holds the number of completed WAIT cycles, so the abort
   // fires during the TIMEOUT_CYCLES-th WAIT cycle.
   assign waitExpired = (state == WAIT) && (waitCount == COUNT_W'(TIMEOUT_CYCLES - 1));
   assign memError    = memErrorReg;

   always_ff @(posedge clk) begin
      if (rst) begin
         waitCount   <= '0;
         memErrorReg <= 1'b0;
      end else begin
         waitCount <= (state == WAIT) ? waitCount + 1'b1 : '0;
         if (waitExpired && !dmemAck) begin
            memErrorReg <= 1'b1;
         end
      end
   end
`else
   logic unusedTimeoutParam;
   assign unusedTimeoutParam = (TIMEOUT_CYCLES != 0);
   assign waitExpired        = 1'b0;
   assign memError           = 1'b0;
`endif

   // Next state, stall and MEM/WB source selection.
   always_comb begin
      stateNext = state;
      memStall  = 1'b0;
      wbLoad    = 1'b0;
      wbNext    = '{instruction:          mem_instruction,
                    shouldWriteRegister:  mem_shouldWriteRegister,
                    registerWriteAddress: mem_registerWriteAddress,
                    registerWriteData:    mem_aluOutput};
      case (state)
         IDLE: begin
            if (access) begin
               memStall  = 1'b1;
               stateNext = WAIT;
            end else begin
               wbLoad = 1'b1;
            end
         end
         WAIT: begin
            memStall = 1'b1;
            if (dmemAck || waitExpired) begin
               stateNext = DONE;
            end
         end
         DONE: begin
            // EX/MEM still holds the access instruction; it retires now.
            wbLoad    = 1'b1;
            stateNext = IDLE;
            if (mem_shouldWriteMemoryElseAluOutputToRegister) begin
               wbNext.registerWriteData = capturedData;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // State register and request/response handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         dmemRequest     <= 1'b0;
         dmemWriteEnable <= 1'b0;
         dmemAddress     <= '0;
         dmemWriteData   <= '0;
         capturedData    <= '0;
      end else begin
         state <= stateNext;
         case (state)
            IDLE: begin
               if (access) begin
                  dmemRequest     <= 1'b1;
                  dmemWriteEnable <= mem_shouldWriteMemory;
                  dmemAddress     <= mem_aluOutput[ADDR_WIDTH+1:2];
                  dmemWriteData   <= mem_registerRtOrZero;
               end
            end
            WAIT: begin
               if (dmemAck) begin
                  dmemRequest  <= 1'b0;
                  capturedData <= dmemReadData;
               end else if (waitExpired) begin
                  dmemRequest  <= 1'b0;
                  capturedData <= 32'h0;
               end
            end
            default: ;
         endcase
      end
   end

   mem_wb_registers uWbRegs (
      .clk                     (clk),
      .rst                     (rst),
      .loadEnable              (wbLoad),
      .wbIn                    (wbNext),
      .wb_instruction          (wb_instruction),
      .wb_shouldWriteRegister  (wb_shouldWriteRegister),
      .wb_registerWriteAddress (wb_registerWriteAddress),
      .wb_registerWriteData    (wb_registerWriteData)
   );

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// Self-checking bench for mem_stage_access_unit: directed scenarios plus
// randomized ALU/load/store traffic, scoreboard queue with a separate
// MEM/WB monitor and a memory responder with configurable ack delay.
module tb_mem_stage_access_unit;

   localparam int TOUT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] mem_instruction;
   logic        mem_shouldWriteRegister;
   logic [4:0]  mem_registerWriteAddress;
   logic        mem_shouldWriteMemoryElseAluOutputToRegister;
   logic [31:0] mem_aluOutput;
   logic        mem_shouldWriteMemory;
   logic [31:0] mem_registerRtOrZero;
   logic        dmemRequest;
   logic        dmemWriteEnable;
   logic [9:0]  dmemAddress;
   logic [31:0] dmemWriteData;
   logic [31:0] dmemReadData;
   logic        dmemAck;
   logic        memStall;
   logic        memError;
   logic [31:0] wb_instruction;
   logic        wb_shouldWriteRegister;
   logic [4:0]  wb_registerWriteAddress;
   logic [31:0] wb_registerWriteData;

   mem_stage_access_unit #(.ADDR_WIDTH(10), .TIMEOUT_CYCLES(TOUT)) dut (
      .clk                     (clk),
      .rst                     (rst),
      .mem_instruction         (mem_instruction),
      .mem_shouldWriteRegister (mem_shouldWriteRegister),
      .mem_registerWriteAddress(mem_registerWriteAddress),
      .mem_shouldWriteMemoryElseAluOutputToRegister(mem_shouldWriteMemoryElseAluOutputToRegister),
      .mem_aluOutput           (mem_aluOutput),
      .mem_shouldWriteMemory   (mem_shouldWriteMemory),
      .mem_registerRtOrZero    (mem_registerRtOrZero),
      .dmemRequest             (dmemRequest),
      .dmemWriteEnable         (dmemWriteEnable),
      .dmemAddress             (dmemAddress),
      .dmemWriteData           (dmemWriteData),
      .dmemReadData            (dmemReadData),
      .dmemAck                 (dmemAck),
      .memStall                (memStall),
      .memError                (memError),
      .wb_instruction          (wb_instruction),
      .wb_shouldWriteRegister  (wb_shouldWriteRegister),
      .wb_registerWriteAddress (wb_registerWriteAddress),
      .wb_registerWriteData    (wb_registerWriteData)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] instr;
      logic        wr;
      logic [4:0]  waddr;
      logic [31:0] data;
      int          edgeNo;
   } exp_t;

   exp_t        expQ[$];
   int          checkCnt = 0;
   int          passCnt  = 0;
   logic [31:0] respMem  [1024];
   logic [31:0] modelMem [1024];
   int          ackDelay = 0;
   logic        respAck  = 1'b0;
   logic        strayAck = 1'b0;
   logic [31:0] respRdata = '0;
   logic [9:0]  expAddr = '0;
   logic        expWe = 1'b0;
   logic [31:0] expWdata = '0;

   assign dmemAck      = respAck | strayAck;
   assign dmemReadData = respRdata;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checkCnt++;
      if (act === req) passCnt++;
      else $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
   endtask

   task automatic clearInputs();
      mem_instruction          = '0;
      mem_shouldWriteRegister  = 1'b0;
      mem_registerWriteAddress = '0;
      mem_shouldWriteMemoryElseAluOutputToRegister = 1'b0;
      mem_aluOutput            = '0;
      mem_shouldWriteMemory    = 1'b0;
      mem_registerRtOrZero     = '0;
   endtask

   // Present one instruction, wait until the stage accepts it, and record the
   // writeback the instruction must produce. k = ack delay in WAIT cycles
   // (0 = never ack).
   task automatic issue(input logic [31:0] instr, input logic wr, input logic [4:0] waddr,
                        input logic isLoad, input logic isStore, input logic [31:0] alu,
                        input logic [31:0] rt, input int k);
      int       e0;
      int       waitCycles;
      int       budget;
      logic     timedOut;
      logic [9:0] wa;
      exp_t     e;
      mem_instruction          = instr;
      mem_shouldWriteRegister  = wr;
      mem_registerWriteAddress = waddr;
      mem_shouldWriteMemoryElseAluOutputToRegister = isLoad;
      mem_aluOutput            = alu;
      mem_shouldWriteMemory    = isStore;
      mem_registerRtOrZero     = rt;
      wa         = alu[11:2];
      ackDelay   = k;
      expAddr    = wa;
      expWe      = isStore;
      expWdata   = rt;
      e0         = cyc;
      waitCycles = k;
      timedOut   = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      if (k == 0) begin
         waitCycles = TOUT;
         timedOut   = 1'b1;
      end
`endif
      budget = 0;
      forever begin
         @(negedge clk);
         if (!memStall) break;
         budget++;
         if (budget > 300) begin
            $display("FAIL accept_wait: instruction %h still stalled after %0d cycles, required acceptance", instr, budget);
            $fatal(1, "stall bound expired");
         end
      end
      e.edgeNo = cyc + 1;
      check("accept_edge", 32'(e.edgeNo), 32'((isLoad || isStore) ? e0 + 2 + waitCycles : e0 + 1));
      e.instr = instr;
      e.wr    = wr;
      e.waddr = waddr;
      if (isLoad) e.data = timedOut ? 32'h0 : modelMem[wa];
      else        e.data = alu;
      if (isStore && !timedOut) modelMem[wa] = rt;
      expQ.push_back(e);
      @(posedge clk);
      #1;
      clearInputs();
   endtask

   // Monitor: every nonzero MEM/WB instruction retires one scoreboard entry;
   // everything else must be an all-zero bubble.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (wb_instruction != 32'h0) begin
            if (expQ.size() == 0) begin
               check("wb_unexpected", wb_instruction, 32'h0);
            end else begin
               e = expQ.pop_front();
               $display("wb retire instr=%h wr=%0d addr=%0d data=%h cycle=%0d",
                        wb_instruction, wb_shouldWriteRegister, wb_registerWriteAddress,
                        wb_registerWriteData, cyc);
               check("wb_instruction", wb_instruction, e.instr);
               check("wb_shouldWrite", 32'(wb_shouldWriteRegister), 32'(e.wr));
               check("wb_writeAddress", 32'(wb_registerWriteAddress), 32'(e.waddr));
               check("wb_writeData", wb_registerWriteData, e.data);
               check("wb_edge", 32'(cyc), 32'(e.edgeNo));
            end
         end else begin
            check("bubble", {wb_registerWriteData[31:6], wb_shouldWriteRegister, wb_registerWriteAddress} |
                            {26'h0, wb_registerWriteData[5:0]}, 32'h0);
         end
      end
   end

   // Memory responder: acks after ackDelay request cycles and checks the
   // request fields against what the bench expects.
   initial begin
      int cnt;
      cnt = 0;
      forever begin
         @(posedge clk);
         #1;
         respAck = 1'b0;
         if (dmemRequest) begin
            cnt++;
            check("req_address", 32'(dmemAddress), 32'(expAddr));
            check("req_writeEnable", 32'(dmemWriteEnable), 32'(expWe));
            if (expWe) check("req_writeData", dmemWriteData, expWdata);
            if (cnt == ackDelay) begin
               respAck   = 1'b1;
               respRdata = respMem[dmemAddress];
               if (dmemWriteEnable) respMem[dmemAddress] = dmemWriteData;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   initial begin
      logic [31:0] v;
      int          kind;
      for (int i = 0; i < 1024; i++) begin
         v           = $urandom;
         respMem[i]  = v;
         modelMem[i] = v;
      end
      rst = 1'b1;
      clearInputs();
      repeat (3) @(posedge clk);
      #1;
      check("rst_request", 32'(dmemRequest), 32'h0);
      check("rst_writeEnable", 32'(dmemWriteEnable), 32'h0);
      check("rst_address", 32'(dmemAddress), 32'h0);
      check("rst_writeData", dmemWriteData, 32'h0);
      check("rst_memError", 32'(memError), 32'h0);
      check("rst_wb_instruction", wb_instruction, 32'h0);
      check("rst_memStall", 32'(memStall), 32'h0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // ALU op
      issue(32'h0000_1111, 1'b1, 5'd5, 1'b0, 1'b0, 32'h1234, 32'h0, 1);
      // load, ack two WAIT cycles after request
      respMem[16]  = 32'hDEADBEEF;
      modelMem[16] = 32'hDEADBEEF;
      issue(32'h0000_2222, 1'b1, 5'd7, 1'b1, 1'b0, 32'h40, 32'h0, 2);
      // store, ack in first WAIT cycle
      issue(32'h0000_3333, 1'b0, 5'd0, 1'b0, 1'b1, 32'h8, 32'hCAFE, 1);
      issue(32'h0000_3334, 1'b1, 5'd9, 1'b1, 1'b0, 32'h8, 32'h0, 3);

      // reset while in WAIT abandons the access
      mem_instruction = 32'h0000_4444;
      mem_shouldWriteRegister  = 1'b1;
      mem_registerWriteAddress = 5'd3;
      mem_shouldWriteMemoryElseAluOutputToRegister = 1'b1;
      mem_aluOutput = 32'h80;
      ackDelay = 0;
      expAddr  = 10'h20;
      expWe    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("wait_request", 32'(dmemRequest), 32'h1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_in_wait_request", 32'(dmemRequest), 32'h0);
      check("rst_in_wait_wb", wb_instruction | wb_registerWriteData, 32'h0);
      rst = 1'b0;
      clearInputs();
      @(posedge clk);
      #1;
      issue(32'h0000_5555, 1'b1, 5'd4, 1'b1, 1'b0, 32'h80, 32'h0, 1);

      // stray ack in IDLE during an ALU op
      strayAck = 1'b1;
      issue(32'h0000_6666, 1'b1, 5'd6, 1'b0, 1'b0, 32'hABCD, 32'h0, 1);
      strayAck = 1'b0;
      check("stray_ack_request", 32'(dmemRequest), 32'h0);

`ifdef MEM_ACCESS_TIMEOUT_EN
      issue(32'h0000_7777, 1'b1, 5'd8, 1'b1, 1'b0, 32'h44, 32'h0, 0);
      check("timeout_memError", 32'(memError), 32'h1);
`endif

      for (int n = 0; n < 80; n++) begin
         kind = $urandom_range(0, 2);
         v    = $urandom & 32'hFFFF_F03F;
         case (kind)
            0: issue($urandom | 32'h1, 1'($urandom), 5'($urandom), 1'b0, 1'b0, $urandom, $urandom, 1);
            1: issue($urandom | 32'h1, 1'($urandom), 5'($urandom), 1'b1, 1'b0, v, $urandom,
                     $urandom_range(1, 4));
            default: issue($urandom | 32'h1, 1'($urandom), 5'($urandom), 1'b0, 1'b1, v, $urandom,
                           $urandom_range(1, 4));
         endcase
      end

      repeat (5) @(posedge clk);
      #1;
      check("scoreboard_empty", 32'(expQ.size()), 32'h0);
`ifdef MEM_ACCESS_TIMEOUT_EN
      check("final_memError", 32'(memError), 32'h1);
`else
      check("final_memError", 32'(memError), 32'h0);
`endif
      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end

endmodule
